// File: rtl/apb_arbiter_2m.sv
// Two-master / one-slave APB arbiter with round-robin tie-break and an
// ACCESS-phase timeout that completes a hung transfer with an error.
module apb_arbiter_2m #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk_i,
    input  logic              presetn_i,

    input  logic              m0_psel_i,
    input  logic              m0_penable_i,
    input  logic [ADDR_W-1:0] m0_paddr_i,
    input  logic [DATA_W-1:0] m0_pwdata_i,
    input  logic              m0_pwrite_i,
    output logic [DATA_W-1:0] m0_prdata_o,
    output logic              m0_pready_o,
    output logic              m0_pslverr_o,

    input  logic              m1_psel_i,
    input  logic              m1_penable_i,
    input  logic [ADDR_W-1:0] m1_paddr_i,
    input  logic [DATA_W-1:0] m1_pwdata_i,
    input  logic              m1_pwrite_i,
    output logic [DATA_W-1:0] m1_prdata_o,
    output logic              m1_pready_o,
    output logic              m1_pslverr_o,

    output logic              s_psel_o,
    output logic              s_penable_o,
    output logic [ADDR_W-1:0] s_paddr_o,
    output logic [DATA_W-1:0] s_pwdata_o,
    output logic              s_pwrite_o,
    input  logic [DATA_W-1:0] s_prdata_i,
    input  logic              s_pready_i,
    input  logic              s_pslverr_i,

    output logic [1:0]        grant_o,
    output logic [7:0]        timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_K = 8'(TIMEOUT);

    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_last_m1;
    logic [7:0] r_k;
    logic [7:0] r_tcnt;
    logic       r_psel;
    logic       r_penable;

    logic [7:0] w_k_next;
    logic       w_access;
    logic       w_done;
    logic       w_tout;
    logic       w_fin;
    logic [1:0] w_pick;
    logic       w_unused;

    // Master-side enables are not part of arbitration.
    assign w_unused = ^{m0_penable_i, m1_penable_i};

    assign w_k_next = r_k + 8'd1;
    // Gating with presetn_i abandons the in-flight transfer during the reset cycle.
    assign w_access = presetn_i && (r_state == ACCESS);
    assign w_done   = w_access && s_pready_i;
    assign w_tout   = w_access && !s_pready_i && (w_k_next == TIMEOUT_K);
    assign w_fin    = w_done || w_tout;

    always_comb begin
        w_pick = 2'b00;
        if (m0_psel_i && m1_psel_i) begin
            w_pick = r_last_m1 ? 2'b01 : 2'b10;
        end else if (m0_psel_i) begin
            w_pick = 2'b01;
        end else if (m1_psel_i) begin
            w_pick = 2'b10;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last_m1 <= 1'b1;
            r_k       <= '0;
            r_tcnt    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_grant <= w_pick;
                        r_psel  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_k       <= '0;
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    r_k <= w_k_next;
                    if (w_fin) begin
                        r_last_m1 <= r_grant[1];
                        r_grant   <= 2'b00;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= IDLE;
                        if (w_tout && (r_tcnt != 8'hFF)) begin
                            r_tcnt <= r_tcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_grant   <= 2'b00;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign s_psel_o      = r_psel;
    assign s_penable_o   = r_penable;
    assign grant_o       = r_grant;
    assign timeout_cnt_o = r_tcnt;

    always_comb begin
        s_paddr_o  = '0;
        s_pwdata_o = '0;
        s_pwrite_o = 1'b0;
        if (r_grant[0]) begin
            s_paddr_o  = m0_paddr_i;
            s_pwdata_o = m0_pwdata_i;
            s_pwrite_o = m0_pwrite_i;
        end else if (r_grant[1]) begin
            s_paddr_o  = m1_paddr_i;
            s_pwdata_o = m1_pwdata_i;
            s_pwrite_o = m1_pwrite_i;
        end
    end

    always_comb begin
        m0_pready_o  = w_fin && r_grant[0];
        m0_pslverr_o = r_grant[0] && (w_tout || (w_done && s_pslverr_i));
        m0_prdata_o  = (r_grant[0] && w_done) ? s_prdata_i : '0;
        m1_pready_o  = w_fin && r_grant[1];
        m1_pslverr_o = r_grant[1] && (w_tout || (w_done && s_pslverr_i));
        m1_prdata_o  = (r_grant[1] && w_done) ? s_prdata_i : '0;
    end

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// Randomized bench for apb_arbiter_2m: two master agents and a slave responder,
// all outputs checked every cycle against a transfer-level reference model.
module tb_apb_arbiter_2m;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
    logic [AW-1:0] m0_paddr;
    logic [DW-1:0] m0_pwdata, m0_prdata;
    logic          m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
    logic [AW-1:0] m1_paddr;
    logic [DW-1:0] m1_pwdata, m1_prdata;
    logic          s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;
    logic [1:0]    grant;
    logic [7:0]    tcnt;

    always #5 clk = ~clk;

    apb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk_i(clk), .presetn_i(rstn),
        .m0_psel_i(m0_psel), .m0_penable_i(m0_penable), .m0_paddr_i(m0_paddr),
        .m0_pwdata_i(m0_pwdata), .m0_pwrite_i(m0_pwrite), .m0_prdata_o(m0_prdata),
        .m0_pready_o(m0_pready), .m0_pslverr_o(m0_pslverr),
        .m1_psel_i(m1_psel), .m1_penable_i(m1_penable), .m1_paddr_i(m1_paddr),
        .m1_pwdata_i(m1_pwdata), .m1_pwrite_i(m1_pwrite), .m1_prdata_o(m1_prdata),
        .m1_pready_o(m1_pready), .m1_pslverr_o(m1_pslverr),
        .s_psel_o(s_psel), .s_penable_o(s_penable), .s_paddr_o(s_paddr),
        .s_pwdata_o(s_pwdata), .s_pwrite_o(s_pwrite), .s_prdata_i(s_prdata),
        .s_pready_i(s_pready), .s_pslverr_i(s_pslverr),
        .grant_o(grant), .timeout_cnt_o(tcnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one transfer at a time, k = ACCESS cycle index (0 = SETUP).
    bit            busy;
    int            owner, k, last, tocnt, wait_n, fin_cnt;
    bit            req[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdat[2];
    bit            wr[2];
    int            gap[2];
    bit            en[2];
    int            gap_max, force_w;
    logic [1:0]    gq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int m);
        req[m]  = 1'b1;
        addr[m] = AW'($urandom);
        wdat[m] = $urandom;
        wr[m]   = 1'($urandom_range(0, 1));
    endtask

    task automatic step(input bit rst_cycle);
        bit            acc, rdy, tout, fin, pr, er;
        logic [DW-1:0] rd_v, ex_d;
        logic          err_v;
        logic [1:0]    ex_g;
        for (int m = 0; m < 2; m++) begin
            if (!req[m] && en[m]) begin
                if (gap[m] == 0) new_req(m);
                else gap[m]--;
            end
        end
        rstn       = !rst_cycle;
        m0_psel    = req[0]; m0_paddr = addr[0]; m0_pwdata = wdat[0]; m0_pwrite = wr[0];
        m1_psel    = req[1]; m1_paddr = addr[1]; m1_pwdata = wdat[1]; m1_pwrite = wr[1];
        m0_penable = 1'($urandom_range(0, 1));
        m1_penable = 1'($urandom_range(0, 1));
        acc        = busy && (k >= 1);
        rdy        = acc && (k > wait_n);
        rd_v       = $urandom;
        err_v      = 1'($urandom_range(0, 1));
        s_pready   = rdy;
        s_prdata   = rd_v;
        s_pslverr  = err_v;
        @(negedge clk);
        tout = acc && !rdy && (k == TO);
        fin  = (rdy || tout) && !rst_cycle;
        if (!rst_cycle) begin
            ex_g = busy ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("s_psel",    s_psel,    busy);
            chk("s_penable", s_penable, acc);
            chk("grant",     grant,     ex_g);
            chk("s_paddr",   s_paddr,   busy ? addr[owner] : '0);
            chk("s_pwdata",  s_pwdata,  busy ? wdat[owner] : '0);
            chk("s_pwrite",  s_pwrite,  busy ? wr[owner] : 1'b0);
        end
        for (int m = 0; m < 2; m++) begin
            pr   = fin && (owner == m);
            er   = pr && (tout || err_v);
            ex_d = (pr && rdy) ? rd_v : '0;
            if (m == 0) begin
                chk("m0_pready", m0_pready, pr); chk("m0_pslverr", m0_pslverr, er);
                chk("m0_prdata", m0_prdata, ex_d);
            end else begin
                chk("m1_pready", m1_pready, pr); chk("m1_pslverr", m1_pslverr, er);
                chk("m1_prdata", m1_prdata, ex_d);
            end
        end
        chk("timeout_cnt", tcnt, tocnt);
        if (fin) gq.push_back(grant);
        if (rst_cycle) begin
            busy = 0; last = 1; tocnt = 0;
        end else if (!busy) begin
            if (req[0] || req[1]) begin
                owner  = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
                busy   = 1;
                k      = 0;
                wait_n = (force_w >= 0) ? force_w : $urandom_range(0, TO + 1);
            end
        end else if (fin) begin
            busy = 0;
            last = owner;
            fin_cnt++;
            if (tout && tocnt < 255) tocnt++;
            req[owner] = 0;
            gap[owner] = $urandom_range(0, gap_max);
        end else begin
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        en[0] = 0; en[1] = 0;
        for (int i = 0; i < 200 && (busy || req[0] || req[1]); i++) step(0);
        chk("drain_idle", {busy, req[0], req[1]}, 3'b000);
    endtask

    initial begin
        busy = 0; owner = 0; k = 0; last = 1; tocnt = 0; wait_n = 0; fin_cnt = 0;
        gap_max = 0; force_w = 0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; addr[m] = '0; wdat[m] = '0; wr[m] = 0; gap[m] = 0; en[m] = 0;
        end
        rstn = 1'b0;
        m0_psel = 0; m0_penable = 0; m0_paddr = '0; m0_pwdata = '0; m0_pwrite = 0;
        m1_psel = 0; m1_penable = 0; m1_paddr = '0; m1_pwdata = '0; m1_pwrite = 0;
        s_pready = 0; s_prdata = '0; s_pslverr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_psel", s_psel, 1'b0);
        chk("rst_tcnt", tcnt, 8'd0);

        // Single m0 write, zero-wait slave: pready on the third cycle.
        req[0] = 1; addr[0] = 8'h05; wdat[0] = 32'hA5A5_0001; wr[0] = 1;
        force_w = 0;
        step(0); step(0);
        chk("lat_before", fin_cnt, 0);
        step(0);
        chk("lat_single", fin_cnt, 1);
        chk("single_grant", gq.size() > 0 ? gq[gq.size()-1] : 2'b11, 2'b01);
        drain();

        // Tie after reset: strict alternation starting with m0.
        step(1);
        gq.delete();
        new_req(0); new_req(1);
        en[0] = 1; en[1] = 1; gap_max = 0; force_w = 0;
        for (int i = 0; i < 40 && gq.size() < 4; i++) step(0);
        drain();
        for (int i = 0; i < 4; i++) chk("rr_order", gq.size() > i ? gq[i] : 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10);

        // Wait states below the timeout, then pready exactly on ACCESS cycle TO.
        new_req(1); force_w = 3;
        drain();
        chk("wait_no_count", tcnt, 8'd0);
        new_req(0); force_w = TO - 1;
        drain();
        chk("boundary_no_count", tcnt, 8'd0);

        // Dead slave: repeated forced completions saturate the counter.
        fin_cnt = 0; force_w = TO + 1; en[0] = 1; gap_max = 0;
        for (int i = 0; i < 300 * (TO + 4) && fin_cnt < 300; i++) step(0);
        drain();
        chk("timeouts_done", fin_cnt, 300);
        chk("tcnt_saturated", tcnt, 8'd255);

        // Random traffic from both masters with random slave latency.
        step(1);
        force_w = -1; gap_max = 2; en[0] = 1; en[1] = 1;
        for (int i = 0; i < 3000; i++) step(0);
        drain();

        // Reset during a wait state, then a tie must go to m0.
        new_req(1); force_w = TO + 1;
        for (int i = 0; i < 20 && !(busy && k == 2); i++) step(0);
        chk("reached_wait", {busy, 8'(k)}, {1'b1, 8'd2});
        step(1);
        new_req(0); force_w = 0;
        step(0);
        chk("tie_after_rst", grant, 2'b01);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
